// File: rtl/ulpi_tx_packet_if.sv
// ULPI link-side bus: the PHY drives DIR/NXT, and the link drives STP and the data byte with its tristate enable.
interface ulpi_tx_packet_if;
    logic       DIR;
    logic       NXT;
    logic       STP;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (input DIR, NXT, output STP, data_out, data_oe);
    modport slave  (output DIR, NXT, input STP, data_out, data_oe);
endinterface

// File: rtl/ulpi_tx_packet.sv
// ULPI link transmitter: sends TXCMD, then the buffered payload, then CRC16, then STP.
// The PHY can take the bus back at any time, which drops the packet.
module ulpi_tx_packet (
    input  logic             CLKOUT,
    input  logic             RESET,
    ulpi_tx_packet_if.master ulpi,
    input  logic             buf_we,
    input  logic [5:0]       buf_addr,
    input  logic [7:0]       buf_wdata,
    input  logic             tx_start,
    input  logic [3:0]       tx_pid,
    input  logic [6:0]       tx_len,
    output logic             busy,
    output logic             done,
    output logic             abort
);

    typedef enum logic [2:0] {
        IDLE, ARM, TXCMD, DATA, CRC_LO, CRC_HI, STOP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  mem [64];
    logic [3:0]  pid;
    logic [6:0]  len;
    logic [6:0]  idx;
    logic [15:0] crc;
    logic        dir_q;
    logic        is_data_pid;
    logic        on_bus;
    logic        last_byte;
    logic [7:0]  cur_byte;

    // CRC-16/USB: the reflected polynomial is applied LSB first, and the register is inverted only at output.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    assign is_data_pid = (pid == 4'h3) || (pid == 4'hB) || (pid == 4'h7) || (pid == 4'hF);
    assign on_bus      = state inside {TXCMD, DATA, CRC_LO, CRC_HI};
    assign last_byte   = (idx == len - 7'd1);
    assign cur_byte    = mem[idx[5:0]];

    // NOTE: the payload RAM has no reset, so it can map onto RAM primitives; every byte is written before it is sent.
    always_ff @(posedge CLKOUT) begin
        if (buf_we)
            mem[buf_addr] <= buf_wdata;
    end

    always_ff @(posedge CLKOUT or posedge RESET) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        // NOTE: state_nxt gets a default first, so every path assigns it and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE:   if (tx_start) state_nxt = ARM;
            // The bus turnaround completes only after DIR has been low for two consecutive edges.
            ARM:    if (!ulpi.DIR && !dir_q) state_nxt = TXCMD;
            TXCMD: begin
                if (ulpi.DIR)
                    state_nxt = IDLE;
                else if (ulpi.NXT) begin
                    if (!is_data_pid)
                        state_nxt = STOP;
                    else if (len != 7'd0)
                        state_nxt = DATA;
                    else
                        state_nxt = CRC_LO;
                end
            end
            DATA: begin
                if (ulpi.DIR)
                    state_nxt = IDLE;
                else if (ulpi.NXT && last_byte)
                    state_nxt = CRC_LO;
            end
            CRC_LO: begin
                if (ulpi.DIR)
                    state_nxt = IDLE;
                else if (ulpi.NXT)
                    state_nxt = CRC_HI;
            end
            CRC_HI: begin
                if (ulpi.DIR)
                    state_nxt = IDLE;
                else if (ulpi.NXT)
                    state_nxt = STOP;
            end
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register sees pre-edge values.
    always_ff @(posedge CLKOUT or posedge RESET) begin
        if (RESET) begin
            pid   <= 4'h0;
            len   <= 7'd0;
            idx   <= 7'd0;
            crc   <= 16'hFFFF;
            dir_q <= 1'b1;
            done  <= 1'b0;
            abort <= 1'b0;
        end else begin
            dir_q <= ulpi.DIR;
            done  <= (state == STOP);
            abort <= on_bus && ulpi.DIR;
            if (state == IDLE && tx_start) begin
                pid <= tx_pid;
                len <= (tx_len > 7'd64) ? 7'd64 : tx_len;
                idx <= 7'd0;
                crc <= 16'hFFFF;
            end else if (state == DATA && !ulpi.DIR && ulpi.NXT) begin
                crc <= crc16_byte(crc, cur_byte);
                idx <= idx + 7'd1;
            end
        end
    end

    always_comb begin
        ulpi.STP      = 1'b0;
        ulpi.data_out = 8'h00;
        unique case (state)
            TXCMD:   ulpi.data_out = 8'h40 | {4'h0, pid};
            DATA:    ulpi.data_out = cur_byte;
            CRC_LO:  ulpi.data_out = ~crc[7:0];
            CRC_HI:  ulpi.data_out = ~crc[15:8];
            STOP:    ulpi.STP      = 1'b1;
            default: ulpi.data_out = 8'h00;
        endcase
        ulpi.data_oe = (on_bus || state == STOP) && !ulpi.DIR;
        busy         = (state != IDLE);
    end

endmodule

// File: tb/tb_ulpi_tx_packet.sv
// Directed bench for ulpi_tx_packet: a small PHY model accepts bytes, and scenario tasks compare them against hand-computed sequences.
module tb_ulpi_tx_packet;
    logic       CLKOUT = 1'b0;
    logic       RESET  = 1'b1;
    logic       buf_we = 1'b0;
    logic [5:0] buf_addr = 6'd0;
    logic [7:0] buf_wdata = 8'h00;
    logic       tx_start = 1'b0;
    logic [3:0] tx_pid = 4'h0;
    logic [6:0] tx_len = 7'd0;
    logic       busy, done, abort;

    ulpi_tx_packet_if ulpi ();

    ulpi_tx_packet dut (
        .CLKOUT(CLKOUT), .RESET(RESET), .ulpi(ulpi),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .tx_start(tx_start), .tx_pid(tx_pid), .tx_len(tx_len),
        .busy(busy), .done(done), .abort(abort)
    );

    always #5 CLKOUT = ~CLKOUT;

    int checks = 0;
    int failures = 0;
    logic [7:0] cap[$];
    logic [7:0] exp_q[$];
    logic [7:0] mem_model [64];
    int stp_n, done_n, abort_n, stp_bad, hold_bad, oe_bad;
    bit timed_out, fin_busy;

    // Independent bit-serial CRC-16/USB over the first n bytes of the buffer mirror.
    function automatic logic [15:0] crc_usb(input int n);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++)
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ mem_model[k][b];
                c  = {1'b0, c[15:1]};
                if (fb) c = c ^ 16'hA001;
            end
        return ~c;
    endfunction

    function automatic int first_diff();
        if (cap.size() != exp_q.size()) return (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        foreach (cap[i]) if (cap[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic void build_crc_exp(input logic [3:0] pid, input int n);
        logic [15:0] c;
        exp_q.delete();
        exp_q.push_back(8'h40 | {4'h0, pid});
        for (int i = 0; i < n; i++) exp_q.push_back(mem_model[i]);
        c = crc_usb(n);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
    endfunction

    task automatic write_buf(input int addr, input logic [7:0] data);
        @(negedge CLKOUT);
        buf_we = 1'b1; buf_addr = addr[5:0]; buf_wdata = data;
        mem_model[addr] = data;
        @(negedge CLKOUT);
        buf_we = 1'b0;
    endtask

    // PHY model: accepts each driven byte after an optional random NXT gap. It can raise DIR when byte abort_at is showing, and can poke tx_start at cycle poke_at.
    task automatic run_pkt(input logic [3:0] pid, input logic [6:0] len, input int max_gap,
                           input int abort_at, input int poke_at);
        int gap_left;
        bit fin, hold_chk, dir_set;
        logic [7:0] prev;
        cap.delete();
        stp_n = 0; done_n = 0; abort_n = 0; stp_bad = 0; hold_bad = 0; oe_bad = 0;
        gap_left = 0; fin = 0; hold_chk = 0; dir_set = 0; prev = 8'h00; fin_busy = 1'b1;
        @(negedge CLKOUT);
        tx_pid = pid; tx_len = len; tx_start = 1'b1;
        @(negedge CLKOUT);
        tx_start = 1'b0;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            if (cyc > 0) @(negedge CLKOUT);
            if (cyc == poke_at) begin
                tx_start = 1'b1; tx_pid = 4'h2; tx_len = 7'd0;
            end else
                tx_start = 1'b0;
            if (hold_chk && ulpi.data_oe && ulpi.data_out !== prev) hold_bad++;
            hold_chk = 0;
            if (ulpi.STP) begin
                stp_n++;
                if (ulpi.data_out !== 8'h00) stp_bad++;
            end
            if (done)  begin done_n++;  fin = 1; fin_busy = busy; end
            if (abort) begin abort_n++; fin = 1; fin_busy = busy; end
            ulpi.NXT = 1'b0;
            if (!fin) begin
                if (abort_at >= 0 && !dir_set && ulpi.data_oe && cap.size() == abort_at) begin
                    ulpi.DIR = 1'b1;
                    dir_set = 1;
                    #1;
                    if (ulpi.data_oe !== 1'b0) oe_bad++;
                end else if (ulpi.data_oe && !ulpi.STP) begin
                    if (gap_left > 0) begin
                        gap_left--;
                        hold_chk = 1;
                        prev = ulpi.data_out;
                    end else begin
                        ulpi.NXT = 1'b1;
                        cap.push_back(ulpi.data_out);
                        gap_left = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
                    end
                end
            end
        end
        tx_start = 1'b0; ulpi.NXT = 1'b0; ulpi.DIR = 1'b0;
        timed_out = !fin;
    endtask

    task automatic test_reset();
        ulpi.DIR = 1'b0; ulpi.NXT = 1'b0;
        repeat (3) @(negedge CLKOUT);
        checks++; if (ulpi.STP !== 1'b0) begin failures++; $display("FAIL reset_stp got=%b exp=0", ulpi.STP); end
        checks++; if (ulpi.data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", ulpi.data_out); end
        checks++; if (ulpi.data_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", ulpi.data_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({done, abort} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {done, abort}); end
        RESET = 1'b0;
    endtask

    task automatic test_nxt_idle();
        ulpi.NXT = 1'b1;
        repeat (3) @(negedge CLKOUT);
        checks++; if ({busy, ulpi.data_oe, ulpi.data_out} !== 10'h000) begin
            failures++; $display("FAIL nxt_idle got busy=%b oe=%b data=%h exp=0/0/00", busy, ulpi.data_oe, ulpi.data_out); end
        ulpi.NXT = 1'b0;
    endtask

    task automatic check_clean_end(input string name);
        int d;
        d = first_diff();
        checks++; if (timed_out) begin failures++; $display("FAIL %s_timeout got=timeout exp=done", name); end
        checks++; if (d != -1) begin failures++; $display("FAIL %s_bytes got=%h at %0d of %0d exp=%h of %0d", name,
            (d < cap.size()) ? cap[d] : 8'hxx, d, cap.size(), (d < exp_q.size()) ? exp_q[d] : 8'hxx, exp_q.size()); end
        checks++; if (stp_n != 1 || stp_bad != 0) begin failures++; $display("FAIL %s_stp got=%0d cycles bad=%0d exp=1 bad=0", name, stp_n, stp_bad); end
        checks++; if (done_n != 1 || abort_n != 0) begin failures++; $display("FAIL %s_pulse got done=%0d abort=%0d exp=1/0", name, done_n, abort_n); end
        @(negedge CLKOUT);
        checks++; if ({done, busy} !== 2'b00) begin failures++; $display("FAIL %s_after got done=%b busy=%b exp=0/0", name, done, busy); end
    endtask

    task automatic test_handshake();
        run_pkt(4'h2, 7'd0, 0, -1, -1);
        exp_q = '{8'h42};
        check_clean_end("handshake");
    endtask

    task automatic test_zero_len();
        run_pkt(4'hB, 7'd0, 0, -1, -1);
        exp_q = '{8'h4B, 8'h00, 8'h00};
        check_clean_end("zero_len");
    endtask

    task automatic test_crc();
        run_pkt(4'h3, 7'd9, 0, -1, -1);
        exp_q = '{8'h43, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
        check_clean_end("crc");
    endtask

    task automatic test_stall();
        run_pkt(4'h3, 7'd9, 5, -1, -1);
        exp_q = '{8'h43, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
        check_clean_end("stall");
        checks++; if (hold_bad != 0) begin failures++; $display("FAIL stall_hold got=%0d changes exp=0", hold_bad); end
    endtask

    task automatic test_abort();
        run_pkt(4'h3, 7'd9, 0, 4, -1);
        exp_q = '{8'h43, 8'h31, 8'h32, 8'h33};
        checks++; if (first_diff() != -1) begin failures++; $display("FAIL abort_bytes got=%0d bytes exp=4", cap.size()); end
        checks++; if (oe_bad != 0) begin failures++; $display("FAIL abort_oe got=%0d exp=0", oe_bad); end
        checks++; if (abort_n != 1 || done_n != 0 || stp_n != 0 || timed_out) begin failures++;
            $display("FAIL abort_pulse got abort=%0d done=%0d stp=%0d to=%b exp=1/0/0/0", abort_n, done_n, stp_n, timed_out); end
        checks++; if (fin_busy !== 1'b0) begin failures++; $display("FAIL abort_idle got busy=%b exp=0", fin_busy); end
        @(negedge CLKOUT);
        checks++; if ({abort, ulpi.STP} !== 2'b00) begin failures++; $display("FAIL abort_after got abort=%b stp=%b exp=0/0", abort, ulpi.STP); end
    endtask

    task automatic test_turnaround();
        @(negedge CLKOUT);
        ulpi.DIR = 1'b1; tx_pid = 4'h2; tx_len = 7'd0; tx_start = 1'b1;
        @(negedge CLKOUT);
        tx_start = 1'b0;
        repeat (3) @(negedge CLKOUT);
        checks++; if ({busy, ulpi.data_oe, ulpi.data_out} !== {1'b1, 1'b0, 8'h00}) begin failures++;
            $display("FAIL turn_arm got busy=%b oe=%b data=%h exp=1/0/00", busy, ulpi.data_oe, ulpi.data_out); end
        ulpi.DIR = 1'b0;
        @(negedge CLKOUT);
        checks++; if ({ulpi.data_oe, ulpi.data_out} !== 9'h000) begin failures++;
            $display("FAIL turn_one_edge got oe=%b data=%h exp=0/00", ulpi.data_oe, ulpi.data_out); end
        @(negedge CLKOUT);
        checks++; if ({ulpi.data_oe, ulpi.data_out} !== {1'b1, 8'h42}) begin failures++;
            $display("FAIL turn_txcmd got oe=%b data=%h exp=1/42", ulpi.data_oe, ulpi.data_out); end
        ulpi.NXT = 1'b1;
        @(negedge CLKOUT);
        ulpi.NXT = 1'b0;
        checks++; if (ulpi.STP !== 1'b1) begin failures++; $display("FAIL turn_stp got=%b exp=1", ulpi.STP); end
        @(negedge CLKOUT);
        checks++; if ({done, busy} !== 2'b10) begin failures++; $display("FAIL turn_done got done=%b busy=%b exp=1/0", done, busy); end
    endtask

    task automatic test_len_limit();
        run_pkt(4'h7, 7'd100, 2, -1, -1);
        build_crc_exp(4'h7, 64);
        check_clean_end("len_limit");
    endtask

    task automatic test_busy_ignore();
        run_pkt(4'h3, 7'd9, 1, -1, 3);
        build_crc_exp(4'h3, 9);
        check_clean_end("busy_ignore");
        repeat (3) @(negedge CLKOUT);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_ignore_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        @(negedge CLKOUT);
        tx_pid = 4'h3; tx_len = 7'd9; tx_start = 1'b1;
        @(negedge CLKOUT);
        tx_start = 1'b0; ulpi.NXT = 1'b1;
        repeat (4) @(negedge CLKOUT);
        RESET = 1'b1;
        #1;
        checks++; if ({ulpi.STP, ulpi.data_oe, busy, ulpi.data_out} !== 11'h000) begin failures++;
            $display("FAIL mid_reset got stp=%b oe=%b busy=%b data=%h exp=0/0/0/00", ulpi.STP, ulpi.data_oe, busy, ulpi.data_out); end
        ulpi.NXT = 1'b0;
        @(negedge CLKOUT);
        RESET = 1'b0;
        repeat (3) begin
            @(negedge CLKOUT);
            if (done || abort || ulpi.STP) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL mid_reset_pulses got=%0d exp=0", pulses); end
        run_pkt(4'h3, 7'd9, 0, -1, -1);
        exp_q = '{8'h43, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
        check_clean_end("mid_reset_restart");
    endtask

    initial begin
        ulpi.DIR = 1'b0;
        ulpi.NXT = 1'b0;
        test_reset();
        for (int i = 0; i < 64; i++) write_buf(i, 8'((i * 7 + 3) & 8'hFF));
        for (int i = 0; i < 9; i++) write_buf(i, 8'(8'h31 + i));
        test_nxt_idle();
        test_handshake();
        test_zero_len();
        test_crc();
        test_stall();
        test_abort();
        test_turnaround();
        test_len_limit();
        test_busy_ignore();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ulpi_tx_packet.md
ULPI_TX_PACKET -- requirements
Module: ulpi_tx_packet

Interface
REQ-001 SHALL have ports: CLKOUT  in  1  60 MHz ULPI clock, sole clock; all logic on posedge.
REQ-002 SHALL have ports: RESET  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: DIR  in  1  PHY bus ownership (1 = PHY drives).
REQ-004 SHALL have ports: NXT  in  1  PHY accepted current byte.
REQ-005 SHALL have ports: STP  out  1  end-of-packet strobe to PHY.
REQ-006 SHALL have ports: data_out  out  8  link-driven ULPI byte; data_oe  out  1  tristate enable.
REQ-007 SHALL have ports: buf_we  in  1, buf_addr  in  6, buf_wdata  in  8  payload buffer write port.
REQ-008 SHALL have ports: tx_start  in  1 (pulse), tx_pid  in  4, tx_len  in  7  packet request.
REQ-009 SHALL have ports: busy  out  1; done  out  1 (pulse); abort  out  1 (pulse).

Function
REQ-010 SHALL hold a 64x8 payload buffer, written on posedge when buf_we=1; contents never reset.
REQ-011 SHALL accept tx_start only in IDLE; latch tx_pid and min(tx_len,64); tx_start while busy ignored.
REQ-012 SHALL classify PID: data PIDs 0x3,0xB,0x7,0xF carry payload+CRC16; all other PIDs are token-less handshakes (TXCMD only, no payload, no CRC).
REQ-013 SHALL implement states IDLE, ARM, TXCMD, DATA, CRC_LO, CRC_HI, STOP.
REQ-014 IDLE->ARM on accepted tx_start; busy=1 in every state except IDLE.
REQ-015 ARM->TXCMD on first edge where DIR=0 on both current and previous edge (bus turnaround); otherwise remain.
REQ-016 TXCMD: data_out=8'h40|pid, held until NXT=1; then ->DATA (len>0), ->CRC_LO (data PID, len=0), ->STOP (handshake).
REQ-017 DATA: data_out=buffer[idx], idx from 0; advance idx only on NXT=1; after byte len-1 accepted ->CRC_LO.
REQ-018 CRC16: poly 0x8005 reflected (0xA001), init 0xFFFF, LSB-first, output inverted; updated only on bytes accepted with NXT=1.
REQ-019 CRC_LO sends CRC[7:0], CRC_HI sends CRC[15:8], each held until NXT=1; CRC_HI accepted ->STOP.
REQ-020 STOP: STP=1, data_out=8'h00 for exactly one cycle; ->IDLE; done=1 for one cycle on the IDLE-entry edge.
REQ-021 STP SHALL be 0 in every state except STOP.
REQ-022 data_oe SHALL equal (state in TXCMD/DATA/CRC_LO/CRC_HI/STOP) AND NOT DIR, combinationally.
REQ-023 DIR=1 sampled in TXCMD, DATA, CRC_LO, CRC_HI SHALL abort: ->IDLE next edge, abort=1 one cycle, no STP, no done.
REQ-024 DIR=1 in STOP SHALL still complete STOP (done asserted); DIR in ARM only delays.
REQ-025 data_out SHALL be 8'h00 in IDLE and ARM.
REQ-026 NXT=1 in IDLE/ARM SHALL be ignored.

Reset
REQ-027 RESET=1 SHALL immediately force IDLE, STP=0, data_out=8'h00, data_oe=0, busy=0, done=0, abort=0, idx=0, CRC=0xFFFF.
REQ-028 RESET asserted mid-packet SHALL drop the transfer without STP, done or abort; first tx_start after release starts cleanly.

Verification
REQ-029 Handshake: tx_pid=0x2, DIR=0, NXT=1 cycle after TXCMD -> data_out 0x42, then STP=1 with 0x00 one cycle, done pulse, no CRC bytes.
REQ-030 Zero-length DATA1: tx_pid=0xB, tx_len=0 -> bytes 0x4B, 0x00, 0x00, then STP; done=1.
REQ-031 CRC check: buffer "123456789" (0x31..0x39), tx_pid=0x3, tx_len=9 -> 0x43, 0x31..0x39, 0xC8, 0xB4, STP.
REQ-032 NXT stalls: random NXT=0 gaps of 0-5 cycles during DATA -> byte held stable, no byte skipped/duplicated, same CRC as REQ-031.
REQ-033 Abort: DIR rises during byte 4 of 9 -> data_oe=0 same cycle, IDLE next edge, abort=1 one cycle, STP never asserted.
REQ-034 Turnaround/limits: tx_start while DIR=1 -> TXCMD only after DIR low two edges; tx_len=100 -> exactly 64 payload bytes; tx_start while busy ignored.
